// File: rtl/ext_sum_accum_pkg.sv
// Shared types and default parameters for the extended-sum group accumulator.
// Build option: define EXT_SUM_ACCUM_SAT_EN for saturating accumulation.
package ext_sum_accum_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ACC_W  = 32;
    localparam int unsigned DEF_GROUP  = 4;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/ext_sum_accum_add.sv
// Combinational signed accumulator adder with overflow flag.
// With EXT_SUM_ACCUM_SAT_EN defined the result clamps on overflow; otherwise it wraps.
module ext_sum_accum_add #(
    parameter int unsigned ACC_W = 32
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum_c,
    output logic             o_ovf_c
);

    logic [ACC_W-1:0] w_raw;

    always_comb begin
        w_raw   = i_a + i_b;
        o_sum_c = w_raw;
        o_ovf_c = 1'b0;
`ifdef EXT_SUM_ACCUM_SAT_EN
        // Same-sign operands producing an opposite-sign result overflowed.
        o_ovf_c = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_raw[ACC_W-1] != i_a[ACC_W-1]);
        if (o_ovf_c) begin
            o_sum_c = i_a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
    end

endmodule

// File: rtl/ext_sum_accum.sv
// Accumulates signed samples into fixed-size groups and emits one sum per group.
// Build option: EXT_SUM_ACCUM_SAT_EN enables saturating sums and the sticky out_sat flag.
module ext_sum_accum
    import ext_sum_accum_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned GROUP  = DEF_GROUP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_sat;
    logic             w_sat_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [ACC_W-1:0] w_sample;
    logic [ACC_W-1:0] w_add_sum;
    logic             w_add_ovf;
    logic             w_accept;
    logic             w_last;

    assign w_sample = ACC_W'($signed(in_data));
    assign w_accept = in_valid && r_in_ready;
    assign w_last   = (r_cnt + CNT_W'(1)) == CNT_W'(GROUP);

    // r_acc is zero in IDLE, so the adder also forms the first sample of a group.
    ext_sum_accum_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .i_a     (r_acc),
        .i_b     (w_sample),
        .o_sum_c (w_add_sum),
        .o_ovf_c (w_add_ovf)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_sat_nxt   = r_sat;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_acc_nxt   = w_add_sum;
                    w_cnt_nxt   = CNT_W'(1);
                    w_sat_nxt   = w_add_ovf;
                    w_state_nxt = flush ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    w_acc_nxt = w_add_sum;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_sat_nxt = r_sat | w_add_ovf;
                end
                if ((w_accept && w_last) || flush) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_sat_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_acc_nxt   = '0;
                w_cnt_nxt   = '0;
                w_sat_nxt   = 1'b0;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they never depend on out_ready combinationally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sat       <= w_sat_nxt;
            r_in_ready  <= (w_state_nxt != HOLD);
            r_out_valid <= (w_state_nxt == HOLD);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_acc;
    assign out_count = r_cnt;
    assign out_sat   = r_sat;

endmodule

// File: tb/tb_ext_sum_accum.sv
// Directed self-checking bench for ext_sum_accum (GROUP = 4, ACC_W = 32).
module tb_ext_sum_accum;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic [7:0]  out_count;
    logic        out_sat;

    int checks = 0;
    int errors = 0;

    ext_sum_accum dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic fl);
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [31:0] s, input logic [7:0] c, input logic sat);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"},   out_sum,         s);
        check({tag, "_count"}, 32'(out_count),  32'(c));
        check({tag, "_sat"},   32'(out_sat),    32'(sat));
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset held for two cycles with in_valid high
        tick();
        tick();
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   out_sum,        32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_sat",   32'(out_sat),   32'd0);
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Full group, no backpressure: 1+2+3-4 = 2
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        check("full_ready_before", 32'(in_ready),  32'd1);
        check("full_valid_before", 32'(out_valid), 32'd0);
        send(32'hFFFF_FFFC, 1'b0);
        check_out("full", 32'd2, 8'd4, 1'b0);
        check("full_ready_hold", 32'(in_ready), 32'd0);
        tick();
        check("full_ready_after", 32'(in_ready),  32'd1);
        check("full_valid_after", 32'(out_valid), 32'd0);

        // Backpressure for five cycles
        out_ready = 1'b0;
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        send(32'hFFFF_FFFC, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_out("bp", 32'd2, 8'd4, 1'b0);
            check("bp_ready", 32'(in_ready), 32'd0);
            tick();
        end
        // Offered sample is refused while in HOLD
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'd77;
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready),  32'd1);
        // Next group starts now; flush with the first sample gives count 1
        send(32'd9, 1'b1);
        check_out("idle_flush_sample", 32'd9, 8'd1, 1'b0);
        tick();

        // Flush after two samples
        send(32'd10, 1'b0);
        send(32'd20, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_out("flush2", 32'd30, 8'd2, 1'b0);
        tick();

        // Flush together with a third accepted sample
        send(32'd10, 1'b0);
        send(32'd20, 1'b0);
        send(32'd5, 1'b1);
        check_out("flush3", 32'd35, 8'd3, 1'b0);
        tick();

        // Flush in IDLE produces nothing
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("idle_flush_valid0", 32'(out_valid), 32'd0);
        tick();
        check("idle_flush_valid1", 32'(out_valid), 32'd0);
        check("idle_flush_ready",  32'(in_ready),  32'd1);

        // Overflow
        for (int i = 0; i < 4; i++) send(32'h7FFF_FFFF, 1'b0);
`ifdef EXT_SUM_ACCUM_SAT_EN
        check_out("ovf", 32'h7FFF_FFFF, 8'd4, 1'b1);
`else
        check_out("ovf", 32'hFFFF_FFFC, 8'd4, 1'b0);
`endif
        tick();
        check("ovf_sat_cleared", 32'(out_sat), 32'd0);

        // Mid-group reset discards partial data
        send(32'd7, 1'b0);
        send(32'd7, 1'b0);
        rst = 1'b0;
        tick();
        check("midrst_ready", 32'(in_ready), 32'd0);
        check("midrst_sum",   out_sum,       32'd0);
        rst = 1'b1;
        tick();
        check("midrst_ready_rel", 32'(in_ready), 32'd1);
        send(32'd1, 1'b0);
        send(32'd1, 1'b0);
        send(32'd1, 1'b0);
        check("midrst_no_early_out", 32'(out_valid), 32'd0);
        send(32'd1, 1'b0);
        check_out("midrst", 32'd4, 8'd4, 1'b0);
        tick();
        check("midrst_single_out", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
